// File: rtl/spi_pkg.sv
// Shared definitions for the SPI slave register bank: FSM encoding,
// register addresses and the command-byte layout.
package spi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CMD,
        ST_WDATA,
        ST_RDATA
    } state_t;

    localparam logic [3:0] REG_ID    = 4'd0;
    localparam logic [3:0] REG_GPIN  = 4'd1;
    localparam logic [3:0] REG_GPOUT = 4'd2;
    localparam logic [3:0] REG_FCNT  = 4'd3;

    localparam int RW_BIT = 7;

    // Registers 0, 1 and 3 are read-only; a write burst skips over them.
    function automatic logic reg_writable(input logic [3:0] addr);
        return !(addr == REG_ID || addr == REG_GPIN || addr == REG_FCNT);
    endfunction

endpackage

// File: rtl/spi_slave_regs_if.sv
// SPI pin bundle between a master and the register-bank slave.
interface spi_slave_regs_if;
    logic spi_clk;
    logic spi_cs_n;
    logic mosi;
    logic miso;
    logic miso_oe;

    modport master (
        output spi_clk,
        output spi_cs_n,
        output mosi,
        input  miso,
        input  miso_oe
    );

    modport slave (
        input  spi_clk,
        input  spi_cs_n,
        input  mosi,
        output miso,
        output miso_oe
    );
endinterface

// File: rtl/spi_pin_sync.sv
// Multi-flop synchronizer for an asynchronous pin, with rise/fall pulses
// derived from the synchronized level.
module spi_pin_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_reg;
    logic              prev_reg;

    // Chain resets to 0 so a pin already low at reset release shows no edge.
    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_stage
            if (gi == 0) begin : g_first
                always_ff @(posedge clk) begin
                    if (reset) sync_reg[0] <= 1'b0;
                    else       sync_reg[0] <= din;
                end
            end else begin : g_rest
                always_ff @(posedge clk) begin
                    if (reset) sync_reg[gi] <= 1'b0;
                    else       sync_reg[gi] <= sync_reg[gi-1];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) prev_reg <= 1'b0;
        else       prev_reg <= sync_reg[STAGES-1];
    end

    assign q    = sync_reg[STAGES-1];
    assign rise = q & ~prev_reg;
    assign fall = ~q & prev_reg;

endmodule

// File: rtl/spi_slave_regs.sv
// SPI mode-0 slave register bank, oversampling the SPI pins on clk.
// Command byte: bit7 = read, bits[3:0] = start address; data bursts auto-increment.
module spi_slave_regs
    import spi_pkg::*;
#(
    parameter logic [7:0] ID_BYTE     = 8'h5A,
    parameter int         SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    spi_slave_regs_if.slave  spi,
    input  logic [7:0]       gpio_in,
    output logic [7:0]       gpio_out
);

    logic sck_q, sck_rise, sck_fall;
    logic cs_n_q, cs_n_rise, cs_n_fall;
    logic mosi_q, mosi_rise, mosi_fall;
    logic unused_sync_bits;

    spi_pin_sync #(.STAGES(SYNC_STAGES)) u_sync_sck (
        .clk(clk), .reset(reset), .din(spi.spi_clk),
        .q(sck_q), .rise(sck_rise), .fall(sck_fall)
    );
    spi_pin_sync #(.STAGES(SYNC_STAGES)) u_sync_cs (
        .clk(clk), .reset(reset), .din(spi.spi_cs_n),
        .q(cs_n_q), .rise(cs_n_rise), .fall(cs_n_fall)
    );
    spi_pin_sync #(.STAGES(SYNC_STAGES)) u_sync_mosi (
        .clk(clk), .reset(reset), .din(spi.mosi),
        .q(mosi_q), .rise(mosi_rise), .fall(mosi_fall)
    );

    assign unused_sync_bits = sck_q ^ mosi_rise ^ mosi_fall;

    state_t      state_reg, state_next;
    logic [2:0]  bit_cnt_reg, bit_cnt_next;
    logic [6:0]  rx_reg, rx_next;
    logic [7:0]  tx_reg, tx_next;
    logic [7:0]  next_byte_reg, next_byte_next;
    logic [3:0]  addr_reg, addr_next;
    logic        cmd_done_reg, cmd_done_next;
    logic [7:0]  fcnt_reg, fcnt_next;
    logic        oe_reg, oe_next;
    logic [7:0]  rw_reg [16];

    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [7:0]  wr_data;
    logic [7:0]  rx_byte;
    logic [3:0]  rd_addr;
    logic [7:0]  rd_data;
    logic        active;

    assign active = ~cs_n_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            bit_cnt_reg   <= '0;
            rx_reg        <= '0;
            tx_reg        <= '0;
            next_byte_reg <= '0;
            addr_reg      <= '0;
            cmd_done_reg  <= 1'b0;
            fcnt_reg      <= '0;
            oe_reg        <= 1'b0;
        end else begin
            state_reg     <= state_next;
            bit_cnt_reg   <= bit_cnt_next;
            rx_reg        <= rx_next;
            tx_reg        <= tx_next;
            next_byte_reg <= next_byte_next;
            addr_reg      <= addr_next;
            cmd_done_reg  <= cmd_done_next;
            fcnt_reg      <= fcnt_next;
            oe_reg        <= oe_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        bit_cnt_next   = bit_cnt_reg;
        rx_next        = rx_reg;
        tx_next        = tx_reg;
        next_byte_next = next_byte_reg;
        addr_next      = addr_reg;
        cmd_done_next  = cmd_done_reg;
        fcnt_next      = fcnt_reg;
        oe_next        = oe_reg;
        wr_en          = 1'b0;
        wr_addr        = addr_reg;
        rx_byte        = {rx_reg, mosi_q};
        wr_data        = rx_byte;

        // In CMD the read address comes straight from the byte just completed.
        rd_addr = (state_reg == ST_CMD) ? rx_byte[3:0] : addr_reg;
        case (rd_addr)
            REG_ID:   rd_data = ID_BYTE;
            REG_GPIN: rd_data = gpio_in;
            REG_FCNT: rd_data = fcnt_reg;
            default:  rd_data = rw_reg[rd_addr];
        endcase

        if (cs_n_rise) begin
            state_next    = ST_IDLE;
            oe_next       = 1'b0;
            tx_next       = '0;
            cmd_done_next = 1'b0;
            if (cmd_done_reg) fcnt_next = fcnt_reg + 8'd1;
        end else if (state_reg == ST_IDLE) begin
            if (cs_n_fall) begin
                state_next    = ST_CMD;
                bit_cnt_next  = '0;
                tx_next       = ID_BYTE;
                oe_next       = 1'b1;
                cmd_done_next = 1'b0;
            end
        end else if (active && sck_rise) begin
            rx_next      = rx_byte[6:0];
            bit_cnt_next = bit_cnt_reg + 3'd1;
            if (bit_cnt_reg == 3'd7) begin
                unique case (state_reg)
                    ST_CMD: begin
                        cmd_done_next = 1'b1;
                        if (rx_byte[RW_BIT]) begin
                            state_next     = ST_RDATA;
                            next_byte_next = rd_data;
                            addr_next      = rx_byte[3:0] + 4'd1;
                        end else begin
                            state_next     = ST_WDATA;
                            next_byte_next = '0;
                            addr_next      = rx_byte[3:0];
                        end
                    end
                    ST_WDATA: begin
                        wr_en          = reg_writable(addr_reg);
                        addr_next      = addr_reg + 4'd1;
                        next_byte_next = '0;
                    end
                    ST_RDATA: begin
                        next_byte_next = rd_data;
                        addr_next      = addr_reg + 4'd1;
                    end
                    default: ;
                endcase
            end
        end else if (active && sck_fall) begin
            // The falling edge after a byte boundary presents the staged byte.
            if (bit_cnt_reg == 3'd0) tx_next = next_byte_reg;
            else                     tx_next = {tx_reg[6:0], 1'b0};
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_reg
            always_ff @(posedge clk) begin
                if (reset)
                    rw_reg[gi] <= '0;
                else if (wr_en && wr_addr == 4'(gi))
                    rw_reg[gi] <= wr_data;
            end
        end
    endgenerate

    assign gpio_out    = rw_reg[REG_GPOUT];
    assign spi.miso    = oe_reg & tx_reg[7];
    assign spi.miso_oe = oe_reg;

endmodule

// File: tb/tb_spi_slave_regs.sv
// Randomized bench for spi_slave_regs: a bit-banged SPI master drives frames
// and a frame-level register model predicts miso bytes and gpio_out.
module tb_spi_slave_regs;

    localparam int HALF = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] gpio_in;
    logic [7:0] gpio_out;

    spi_slave_regs_if spi ();

    spi_slave_regs #(.ID_BYTE(8'h5A), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset(reset), .spi(spi),
        .gpio_in(gpio_in), .gpio_out(gpio_out)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [7:0] m_regs [16];
    logic [7:0] m_fcnt;
    logic [7:0] fq [$];

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%02h exp=%02h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] m_read(input logic [3:0] a);
        case (a)
            4'd0:    return 8'h5A;
            4'd1:    return gpio_in;
            4'd3:    return m_fcnt;
            default: return m_regs[a];
        endcase
    endfunction

    function automatic logic m_writable(input logic [3:0] a);
        return !(a == 4'd0 || a == 4'd1 || a == 4'd3);
    endfunction

    task automatic m_clear();
        for (int i = 0; i < 16; i++) m_regs[i] = 8'h00;
        m_fcnt = 8'h00;
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Mode 0: drive mosi while sck is low, sample miso at the rising edge.
    task automatic xfer_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            spi.mosi = tx[7-i];
            wait_clk(HALF);
            rx = {rx[6:0], spi.miso};
            spi.spi_clk = 1'b1;
            wait_clk(HALF);
            spi.spi_clk = 1'b0;
        end
    endtask

    // Sends the bytes in fq, then tail_bits of a discarded partial byte.
    task automatic run_frame(input int tail_bits, input string tag);
        logic [7:0] rx;
        logic       is_read;
        logic [3:0] addr;
        is_read = (fq.size() > 0) && fq[0][7];
        addr    = (fq.size() > 0) ? fq[0][3:0] : 4'd0;
        spi.spi_cs_n = 1'b0;
        wait_clk(HALF);
        check({tag, ".oe_on"}, {7'd0, spi.miso_oe}, 8'h01);
        for (int k = 0; k < fq.size(); k++) begin
            xfer_bits(fq[k], 8, rx);
            if (k == 0) begin
                check({tag, ".cmd_miso"}, rx, 8'h5A);
            end else if (is_read) begin
                check($sformatf("%s.rd%0d", tag, k), rx, m_read(addr));
                addr = addr + 4'd1;
            end else begin
                if (m_writable(addr)) m_regs[addr] = fq[k];
                addr = addr + 4'd1;
            end
        end
        if (tail_bits > 0) xfer_bits(8'($urandom), tail_bits, rx);
        wait_clk(HALF);
        spi.spi_cs_n = 1'b1;
        wait_clk(8);
        if (fq.size() > 0) m_fcnt = m_fcnt + 8'd1;
        check({tag, ".oe_off"}, {7'd0, spi.miso_oe}, 8'h00);
        check({tag, ".miso_idle"}, {7'd0, spi.miso}, 8'h00);
        check({tag, ".gpio_out"}, gpio_out, m_regs[2]);
        $display("frame %s bytes=%0d tail=%0d fcnt=%02h gpio_out=%02h",
                 tag, fq.size(), tail_bits, m_fcnt, gpio_out);
    endtask

    initial begin
        logic [7:0] rx;
        int         nbytes;
        int         tail;
        logic [7:0] cmd;

        reset        = 1'b1;
        gpio_in      = 8'h00;
        spi.spi_clk  = 1'b0;
        spi.spi_cs_n = 1'b1;
        spi.mosi     = 1'b0;
        m_clear();
        wait_clk(5);
        reset = 1'b0;
        wait_clk(6);
        check("rst.oe", {7'd0, spi.miso_oe}, 8'h00);
        check("rst.miso", {7'd0, spi.miso}, 8'h00);
        check("rst.gpio_out", gpio_out, 8'h00);

        fq = '{8'h80, 8'h00};                 run_frame(0, "id_read");
        fq = '{8'h02, 8'h3C, 8'h11};          run_frame(0, "wr_gpout");
        fq = '{8'h84, 8'h00};                 run_frame(0, "rd_reg4");
        fq = '{8'h0F, 8'hAA, 8'hBB};          run_frame(0, "wr_wrap");
        fq = '{8'h8F, 8'h00, 8'h00};          run_frame(0, "rd_wrap");
        gpio_in = 8'hC3;
        fq = '{8'h81, 8'h00};                 run_frame(0, "rd_gpin");
        fq = '{8'h83, 8'h00};                 run_frame(0, "rd_fcnt");
        fq = '{8'h02};                        run_frame(5, "wr_partial");
        fq = {};                              run_frame(3, "cmd_partial");
        fq = '{8'h83, 8'h00, 8'h00};          run_frame(0, "rd_fcnt2");

        // Reset mid-burst with CS held low: sck activity must be ignored.
        spi.spi_cs_n = 1'b0;
        wait_clk(HALF);
        xfer_bits(8'h02, 8, rx);
        xfer_bits(8'h99, 8, rx);
        wait_clk(4);
        reset = 1'b1;
        wait_clk(3);
        reset = 1'b0;
        m_clear();
        wait_clk(4);
        check("rstmid.gpio_out", gpio_out, 8'h00);
        check("rstmid.oe", {7'd0, spi.miso_oe}, 8'h00);
        xfer_bits(8'h04, 8, rx);
        xfer_bits(8'h55, 8, rx);
        check("rstmid.ignored_miso", rx, 8'h00);
        check("rstmid.oe_held", {7'd0, spi.miso_oe}, 8'h00);
        spi.spi_cs_n = 1'b1;
        wait_clk(8);
        fq = '{8'h80, 8'h00};                 run_frame(0, "post_rst_id");
        fq = '{8'h84, 8'h00};                 run_frame(0, "post_rst_reg4");
        fq = '{8'h83, 8'h00};                 run_frame(0, "post_rst_fcnt");

        for (int f = 0; f < 40; f++) begin
            gpio_in = 8'($urandom);
            nbytes  = int'($urandom_range(0, 4));
            tail    = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 7)) : 0;
            cmd     = 8'($urandom);
            fq = {};
            if (nbytes > 0) fq.push_back(cmd);
            for (int k = 1; k < nbytes; k++) fq.push_back(8'($urandom));
            run_frame(tail, $sformatf("rnd%0d", f));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
